// File: rtl/evu_event_agg.sv
// evu_event_agg: per-channel event counters whose threshold reports are merged round-robin into one output record register
// Ports: clk_i/rst_ni clock and async active-low reset; evt_i event pulses; priv_lvl_i/asid_i current context;
//   cfg_we_i/cfg_ch_i/cfg_sel_i/cfg_en_i/cfg_priv_mask_i/cfg_thresh_i channel configuration write;
//   out_valid_o/out_ready_i with out_ch_o/out_priv_o/out_asid_o record handshake; ovf_o sticky dropped-report flags
module evu_event_agg #(
  parameter int NUM_CH = 4,
  parameter int NUM_EVT = 16,
  parameter int CNT_W = 16,
  parameter int ASID_WIDTH = 16,
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1,
  localparam int EV_W = NUM_EVT > 1 ? $clog2(NUM_EVT) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NUM_EVT-1:0]    evt_i,
  input  logic [1:0]            priv_lvl_i,
  input  logic [ASID_WIDTH-1:0] asid_i,
  input  logic                  cfg_we_i,
  input  logic [CH_W-1:0]       cfg_ch_i,
  input  logic [EV_W-1:0]       cfg_sel_i,
  input  logic                  cfg_en_i,
  input  logic [2:0]            cfg_priv_mask_i,
  input  logic [CNT_W-1:0]      cfg_thresh_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [CH_W-1:0]       out_ch_o,
  output logic [1:0]            out_priv_o,
  output logic [ASID_WIDTH-1:0] out_asid_o,
  output logic [NUM_CH-1:0]     ovf_o
);
  logic [EV_W-1:0] sel_q [NUM_CH];
  logic [2:0] mask_q [NUM_CH];
  logic [CNT_W-1:0] thresh_q [NUM_CH];
  logic [CNT_W-1:0] cnt_q [NUM_CH];
  logic [1:0] snap_priv_q [NUM_CH];
  logic [ASID_WIDTH-1:0] snap_asid_q [NUM_CH];
  logic [NUM_CH-1:0] en_q, pend_q, ovf_q, cfg_hit, hit, th_hit, gnt;
  logic [CH_W-1:0] rr_q, gnt_idx, idx;
  logic gnt_vld, loadable;
  logic [2:0] priv_oh;
  logic [1:0] priv_map;
  // reserved level 10 selects no mask bit, so it can never hit
  assign priv_oh = priv_lvl_i == 2'b00 ? 3'b001 : priv_lvl_i == 2'b01 ? 3'b010 : priv_lvl_i == 2'b11 ? 3'b100 : 3'b000;
  assign priv_map = priv_lvl_i == 2'b11 ? 2'b01 : priv_lvl_i == 2'b01 ? 2'b10 : 2'b11;
  assign loadable = !out_valid_o || out_ready_i;
  assign ovf_o = ovf_q;

  // first pending channel at or after rr_q, which points just past the last grant
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = CH_W'((int'(rr_q) + k) % NUM_CH);
      if (!gnt_vld && pend_q[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      cfg_hit[c] = cfg_we_i && cfg_ch_i == CH_W'(c);
      hit[c] = en_q[c] && evt_i[sel_q[c]] && |(mask_q[c] & priv_oh);
      th_hit[c] = hit[c] && thresh_q[c] != '0 && cnt_q[c] + CNT_W'(1) == thresh_q[c];
      gnt[c] = loadable && gnt_vld && gnt_idx == CH_W'(c);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q <= '0;
      pend_q <= '0;
      ovf_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        sel_q[c] <= '0;
        mask_q[c] <= '0;
        thresh_q[c] <= '0;
        cnt_q[c] <= '0;
        snap_priv_q[c] <= '0;
        snap_asid_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (cfg_hit[c]) begin
          sel_q[c] <= cfg_sel_i;
          en_q[c] <= cfg_en_i;
          mask_q[c] <= cfg_priv_mask_i;
          thresh_q[c] <= cfg_thresh_i;
          cnt_q[c] <= '0;
          pend_q[c] <= 1'b0;
          ovf_q[c] <= 1'b0;
        end else begin
          if (hit[c])
            cnt_q[c] <= th_hit[c] ? '0 : &cnt_q[c] ? cnt_q[c] : cnt_q[c] + CNT_W'(1);
          // an ungranted pending record is kept; the newer report is dropped and flagged
          if (th_hit[c] && pend_q[c] && !gnt[c])
            ovf_q[c] <= 1'b1;
          else if (th_hit[c]) begin
            pend_q[c] <= 1'b1;
            snap_priv_q[c] <= priv_map;
            snap_asid_q[c] <= asid_i;
          end else if (gnt[c])
            pend_q[c] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_o <= 1'b0;
      out_ch_o <= '0;
      out_priv_o <= '0;
      out_asid_o <= '0;
      rr_q <= '0;
    end else if (loadable) begin
      out_valid_o <= gnt_vld;
      if (gnt_vld) begin
        out_ch_o <= gnt_idx;
        out_priv_o <= snap_priv_q[gnt_idx];
        out_asid_o <= snap_asid_q[gnt_idx];
        rr_q <= gnt_idx == CH_W'(NUM_CH - 1) ? '0 : gnt_idx + CH_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_evu_event_agg.sv
// tb_evu_event_agg: vector table, directed corner sequences and randomized model comparison for evu_event_agg
module tb_evu_event_agg;
  localparam int NCH = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] evt = '0;
  logic [1:0] priv = '0;
  logic [15:0] asid = '0;
  logic cfg_we = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [3:0] cfg_sel = '0;
  logic cfg_en = 1'b0;
  logic [2:0] cfg_mask = '0;
  logic [15:0] cfg_th = '0;
  logic ready = 1'b1;
  logic valid;
  logic [1:0] och, opriv;
  logic [15:0] oasid;
  logic [3:0] ovf;
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  evu_event_agg #(.NUM_CH(4), .NUM_EVT(16), .CNT_W(16), .ASID_WIDTH(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .evt_i(evt), .priv_lvl_i(priv), .asid_i(asid),
    .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch), .cfg_sel_i(cfg_sel), .cfg_en_i(cfg_en),
    .cfg_priv_mask_i(cfg_mask), .cfg_thresh_i(cfg_th),
    .out_valid_o(valid), .out_ready_i(ready), .out_ch_o(och), .out_priv_o(opriv),
    .out_asid_o(oasid), .ovf_o(ovf)
  );

  typedef struct {
    logic we; logic [1:0] ch; logic [3:0] sel; logic [2:0] mask; logic [15:0] th;
    logic [15:0] evt; logic [1:0] priv; logic [15:0] asid;
    logic ev; logic [1:0] ech; logic [1:0] epr; logic [15:0] eas;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input int we, ch, sel, mask, th, e, p, a, ev, ech, epr, eas);
    vec_t v;
    v.we = 1'(we); v.ch = 2'(ch); v.sel = 4'(sel); v.mask = 3'(mask); v.th = 16'(th);
    v.evt = 16'(e); v.priv = 2'(p); v.asid = 16'(a);
    v.ev = 1'(ev); v.ech = 2'(ech); v.epr = 2'(epr); v.eas = 16'(eas);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
  endtask

  task automatic chk_out(input string n, input logic v, input logic [1:0] ch, input logic [1:0] pr, input logic [15:0] as);
    check({n, "_valid"}, 32'(valid), 32'(v));
    if (v) begin
      check({n, "_ch"}, 32'(och), 32'(ch));
      check({n, "_priv"}, 32'(opriv), 32'(pr));
      check({n, "_asid"}, 32'(oasid), 32'(as));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int ch, sel, mask, th);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_sel = 4'(sel); cfg_en = 1'b1; cfg_mask = 3'(mask); cfg_th = 16'(th);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cfg_we = 1'b0; evt = '0; ready = 1'b1; priv = '0; asid = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // reference model: channel state as plain arrays, rules applied per clock edge
  int m_sel[NCH], m_en[NCH], m_mask[NCH], m_th[NCH], m_sp[NCH], m_sa[NCH];
  longint m_cnt[NCH];
  bit m_pend[NCH], m_ovf[NCH];
  int m_rr, m_ch, m_pr, m_as;
  bit m_v;

  function automatic void mdl_reset();
    for (int c = 0; c < NCH; c++) begin
      m_sel[c] = 0; m_en[c] = 0; m_mask[c] = 0; m_th[c] = 0; m_sp[c] = 0; m_sa[c] = 0;
      m_cnt[c] = 0; m_pend[c] = 0; m_ovf[c] = 0;
    end
    m_rr = 0; m_v = 0; m_ch = 0; m_pr = 0; m_as = 0;
  endfunction

  function automatic void mdl_tick();
    int g = -1;
    int lvl;
    bit ld, h, rep;
    ld = !m_v || ready;
    for (int k = 0; k < NCH; k++)
      if (g < 0 && m_pend[(m_rr + k) % NCH]) g = (m_rr + k) % NCH;
    if (!ld) g = -1;
    if (ld) begin
      m_v = g >= 0;
      if (g >= 0) begin
        m_ch = g; m_pr = m_sp[g]; m_as = m_sa[g]; m_rr = (g + 1) % NCH;
      end
    end
    lvl = priv == 2'b00 ? 0 : priv == 2'b01 ? 1 : priv == 2'b11 ? 2 : -1;
    for (int c = 0; c < NCH; c++) begin
      h = m_en[c] != 0 && evt[m_sel[c]] && lvl >= 0 && ((m_mask[c] >> lvl) & 1) != 0;
      rep = 0;
      if (cfg_we && int'(cfg_ch) == c) begin
        m_sel[c] = int'(cfg_sel); m_en[c] = int'(cfg_en); m_mask[c] = int'(cfg_mask); m_th[c] = int'(cfg_th);
        m_cnt[c] = 0; m_pend[c] = 0; m_ovf[c] = 0;
      end else begin
        if (h) begin
          if (m_th[c] != 0 && m_cnt[c] + 1 == longint'(m_th[c])) begin
            m_cnt[c] = 0; rep = 1;
          end else if (m_cnt[c] < 65535) m_cnt[c]++;
        end
        if (rep && m_pend[c] && g != c) m_ovf[c] = 1;
        else if (rep) begin
          m_pend[c] = 1; m_sa[c] = int'(asid);
          m_sp[c] = priv == 2'b11 ? 1 : priv == 2'b01 ? 2 : 3;
        end else if (g == c) m_pend[c] = 0;
      end
    end
  endfunction

  initial begin
    bit saw;
    logic [3:0] m_ovf_v;
    do_reset();
    chk_out("rst", 1'b0, 2'd0, 2'd0, 16'd0);
    check("rst_ch", 32'(och), 0);
    check("rst_priv", 32'(opriv), 0);
    check("rst_asid", 32'(oasid), 0);
    check("rst_ovf", 32'(ovf), 0);
    // ch0 count-to-4 in M mode, then ch1 U-only filter with thresh 1
    tbl.push_back(mk(1, 0, 3, 7, 4, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 'h8, 3, 'h12, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3, 'h12, 1, 0, 1, 'h12));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 'h20, 0, 'h21, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 'h20, 1, 'h22, 1, 1, 3, 'h21));
    tbl.push_back(mk(0, 0, 0, 0, 0, 'h20, 0, 'h23, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 'h20, 1, 'h24, 1, 1, 3, 'h23));
    tbl.push_back(mk(0, 0, 0, 0, 0, 'h20, 2, 'h25, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (tbl[i]) begin
      cfg_we = tbl[i].we; cfg_ch = tbl[i].ch; cfg_sel = tbl[i].sel; cfg_en = 1'b1;
      cfg_mask = tbl[i].mask; cfg_th = tbl[i].th;
      evt = tbl[i].evt; priv = tbl[i].priv; asid = tbl[i].asid;
      tick();
      chk_out($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].ech, tbl[i].epr, tbl[i].eas);
      check($sformatf("tbl%0d_ovf", i), 32'(ovf), 0);
      if (i == 5) check("cnt0_reload", 32'(dut.cnt_q[0]), 0);
    end
    // round robin over four simultaneous reports, twice
    do_reset();
    for (int c = 0; c < NCH; c++) begin
      set_cfg(c, 7, 7, 1);
      tick();
    end
    cfg_we = 1'b0;
    for (int r = 0; r < 2; r++) begin
      evt = 16'h0080; priv = 2'b11; asid = 16'(16'h40 + r);
      tick();
      evt = '0;
      check($sformatf("rr%0d_pulse", r), 32'(valid), 0);
      for (int c = 0; c < NCH; c++) begin
        tick();
        chk_out($sformatf("rr%0d_%0d", r, c), 1'b1, 2'(c), 2'b01, 16'(16'h40 + r));
      end
      tick();
      check($sformatf("rr%0d_drain", r), 32'(valid), 0);
    end
    // backpressure: held record, overflow, release
    set_cfg(2, 9, 7, 1);
    tick();
    cfg_we = 1'b0;
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      evt = 16'h0200; priv = 2'b01; asid = 16'(16'h31 + i);
      tick();
      if (i == 0) check("bp_p1_valid", 32'(valid), 0);
      else chk_out($sformatf("bp_p%0d", i + 1), 1'b1, 2'd2, 2'b10, 16'h31);
      check($sformatf("bp_p%0d_ovf", i + 1), 32'(ovf), i == 2 ? 4 : 0);
    end
    evt = '0;
    tick();
    chk_out("bp_hold", 1'b1, 2'd2, 2'b10, 16'h31);
    ready = 1'b1;
    tick();
    chk_out("bp_rel", 1'b1, 2'd2, 2'b10, 16'h32);
    tick();
    check("bp_done_valid", 32'(valid), 0);
    check("bp_ovf_sticky", 32'(ovf), 4);
    set_cfg(2, 9, 7, 1);
    tick();
    cfg_we = 1'b0;
    check("bp_ovf_clr", 32'(ovf), 0);
    // config write beats a coincident hit; thresh 0 saturates silently
    do_reset();
    set_cfg(0, 3, 7, 1);
    tick();
    evt = 16'h0008; priv = 2'b11;
    tick();
    cfg_we = 1'b0; evt = '0;
    tick();
    tick();
    check("cfg_win_valid", 32'(valid), 0);
    check("cfg_win_cnt", 32'(dut.cnt_q[0]), 0);
    set_cfg(0, 3, 7, 0);
    tick();
    cfg_we = 1'b0;
    saw = 0;
    evt = 16'h0008;
    for (int i = 0; i < 65536 + 5; i++) begin
      tick();
      if (valid) saw = 1;
    end
    evt = '0;
    tick();
    check("thr0_no_rec", 32'(saw | valid), 0);
    check("thr0_sat", 32'(dut.cnt_q[0]), 32'hffff);
    // async reset while a record is waiting
    set_cfg(1, 4, 7, 1);
    tick();
    cfg_we = 1'b0;
    ready = 1'b0;
    evt = 16'h0010; priv = 2'b01; asid = 16'h55;
    tick();
    evt = '0;
    tick();
    chk_out("arst_pre", 1'b1, 2'd1, 2'b10, 16'h55);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(valid), 0);
    check("arst_ch", 32'(och), 0);
    check("arst_priv", 32'(opriv), 0);
    check("arst_asid", 32'(oasid), 0);
    check("arst_ovf", 32'(ovf), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("arst_after%0d", i), 32'(valid), 0);
    end
    // randomized traffic against the model
    do_reset();
    mdl_reset();
    for (int n = 0; n < 3000; n++) begin
      cfg_we = $urandom_range(0, 7) == 0;
      cfg_ch = 2'($urandom);
      cfg_sel = 4'($urandom_range(0, 3));
      cfg_en = $urandom_range(0, 3) != 0;
      cfg_mask = 3'($urandom);
      cfg_th = 16'($urandom_range(0, 3));
      evt = 16'($urandom) & 16'h000f;
      priv = 2'($urandom);
      asid = 16'($urandom);
      ready = $urandom_range(0, 3) != 0;
      tick();
      mdl_tick();
      chk_out("rnd", m_v, 2'(m_ch), 2'(m_pr), 16'(m_as));
      for (int c = 0; c < NCH; c++) m_ovf_v[c] = m_ovf[c];
      check("rnd_ovf", 32'(ovf), 32'(m_ovf_v));
      for (int c = 0; c < NCH; c++) check($sformatf("rnd_cnt%0d", c), 32'(dut.cnt_q[c]), 32'(m_cnt[c]));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
